// File: rtl/demux_rr_dispatch.sv
// Round-robin burst dispatcher for a 1-to-seln valid/ready demux.
// One arbitration bubble per burst; the granted channel stays locked until the burst's last word.
module demux_rr_dispatch #(
  parameter int dwidth = 8,
  parameter int swidth = 2,
  parameter int burst  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [dwidth-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [(2**swidth)*dwidth-1:0]   out_data,
  output logic [(2**swidth)-1:0]          out_valid,
  input  logic [(2**swidth)-1:0]          out_ready,
  output logic                            out_last,
  output logic [swidth-1:0]               cur_sel,
  output logic                            busy
);

  localparam int seln   = 2**swidth;
  localparam int cwidth = (burst > 1) ? $clog2(burst) : 1;
  localparam logic [cwidth-1:0] cnt_last = cwidth'(burst - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [swidth-1:0] ptr, ptr_nxt;
  logic [swidth-1:0] sel, sel_nxt;
  logic [cwidth-1:0] cnt, cnt_nxt;

  logic              grant_hit;
  logic [swidth-1:0] grant_idx;
  logic [swidth-1:0] cand;
  logic              xfer_fire;
  logic              burst_end;

  assign cur_sel   = sel;
  assign burst_end = (cnt == cnt_last);
  assign xfer_fire = (state == XFER) && in_valid && out_ready[sel];

  // First ready channel scanning upward from ptr; the add wraps modulo seln for free.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    grant_hit = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int k = 0; k < seln; k++) begin
      cand = ptr + swidth'(k);
      if (!grant_hit && out_ready[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    unique case (state)
      IDLE: begin
        if (in_valid && grant_hit) begin
          sel_nxt   = grant_idx;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (xfer_fire) begin
          if (burst_end) begin
            ptr_nxt   = sel + swidth'(1);
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + cwidth'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: data path is purely combinational, steered by the locked sel
  always_comb begin
    in_ready  = 1'b0;
    out_valid = '0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (state == XFER) begin
      busy                                  = 1'b1;
      in_ready                              = out_ready[sel];
      out_valid[sel]                        = in_valid;
      out_data[int'(sel)*dwidth +: dwidth]  = in_data;
      out_last                              = burst_end && in_valid;
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Bench for demux_rr_dispatch: default instance (4 channels, burst 4) and a 2-channel burst-1 instance,
// each checked every cycle against a burst-level reference model.
module tb_demux_rr_dispatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: dwidth=8, swidth=2, burst=4
  logic        a_rst, a_in_valid, a_in_ready, a_out_last, a_busy;
  logic [7:0]  a_in_data;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [1:0]  a_cur_sel;

  // Instance B: dwidth=8, swidth=1, burst=1
  logic        b_rst, b_in_valid, b_in_ready, b_out_last, b_busy;
  logic [7:0]  b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_valid, b_out_ready;
  logic [0:0]  b_cur_sel;

  demux_rr_dispatch #(.dwidth(8), .swidth(2), .burst(4)) dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
    .cur_sel(a_cur_sel), .busy(a_busy)
  );

  demux_rr_dispatch #(.dwidth(8), .swidth(1), .burst(1)) dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .cur_sel(b_cur_sel), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  string cur_test = "init";
  logic [7:0] next_data = 8'h00;

  // Reference model per instance: granted?, owning channel, words sent in burst, next rr start.
  int m_busy[2], m_owner[2], m_done[2], m_ptr[2];

  // Transfers observed on the output side, in order.
  int         obs_ch[$];
  bit         obs_last[$];
  logic [7:0] obs_data[$];

  task automatic clear_obs();
    obs_ch.delete();
    obs_last.delete();
    obs_data.delete();
  endtask

  // One clock cycle on instance d: drive at negedge, compare just after, advance model at posedge.
  task automatic step(input int d, input bit r, input bit v, input logic [7:0] data,
                      input logic [3:0] rdy, output bit fired);
    logic [40:0] obs, expv;
    logic [3:0]  ev, ov;
    logic [31:0] ed, od;
    bit          el, er;
    int          n, b, ch;
    n = (d == 0) ? 4 : 2;
    b = (d == 0) ? 4 : 1;
    @(negedge clk);
    if (d == 0) begin
      a_rst = r; a_in_valid = v; a_in_data = data; a_out_ready = rdy;
    end else begin
      b_rst = r; b_in_valid = v; b_in_data = data; b_out_ready = rdy[1:0];
    end
    #1;
    if (d == 0)
      obs = {a_in_ready, a_out_valid, a_out_data, a_out_last, a_cur_sel, a_busy};
    else
      obs = {b_in_ready, 2'b00, b_out_valid, 16'h0000, b_out_data, b_out_last, 1'b0, b_cur_sel, b_busy};

    er = (m_busy[d] != 0) && rdy[m_owner[d]];
    ev = ((m_busy[d] != 0) && v) ? 4'(1 << m_owner[d]) : 4'h0;
    ed = (m_busy[d] != 0) ? (32'(data) << (8 * m_owner[d])) : 32'h0;
    el = (m_busy[d] != 0) && v && (m_done[d] == b - 1);
    expv = {er, ev, ed, el, 2'(m_owner[d]), m_busy[d] != 0};

    n_checks++;
    if (obs !== expv)
      $display("FAIL %s outputs dut%0d t=%0t: got rdy=%b vld=%b data=%h last=%b sel=%0d busy=%b, want rdy=%b vld=%b data=%h last=%b sel=%0d busy=%b",
               cur_test, d, $time, obs[40], obs[39:36], obs[35:4], obs[3], obs[2:1], obs[0],
               expv[40], expv[39:36], expv[35:4], expv[3], expv[2:1], expv[0]);
    else
      n_pass++;

    fired = v && (obs[40] === 1'b1) && !r;
    if (fired) begin
      ov = obs[39:36];
      od = obs[35:4];
      ch = -1;
      for (int c = 0; c < 4; c++) if (ov[c] === 1'b1 && ch < 0) ch = c;
      obs_ch.push_back(ch);
      obs_last.push_back(obs[3]);
      obs_data.push_back((ch >= 0) ? od[8*ch +: 8] : 8'h00);
    end

    @(posedge clk);
    if (r) begin
      m_busy[d] = 0; m_owner[d] = 0; m_done[d] = 0; m_ptr[d] = 0;
    end else if (m_busy[d] == 0) begin
      if (v) begin
        for (int k = 0; k < n; k++) begin
          if (m_busy[d] == 0 && rdy[(m_ptr[d] + k) % n]) begin
            m_owner[d] = (m_ptr[d] + k) % n;
            m_busy[d]  = 1;
            m_done[d]  = 0;
          end
        end
      end
    end else if (v && rdy[m_owner[d]]) begin
      m_done[d]++;
      if (m_done[d] == b) begin
        m_ptr[d]  = (m_owner[d] + 1) % n;
        m_busy[d] = 0;
        m_done[d] = 0;
      end
    end
  endtask

  // Stream consecutive data words with a fixed ready pattern until nwords move or budget runs out.
  task automatic stream(input int d, input int nwords, input logic [3:0] rdy,
                        input int budget, output int cycles);
    int sent;
    bit f;
    sent = 0;
    cycles = 0;
    while (sent < nwords && cycles < budget) begin
      step(d, 1'b0, 1'b1, next_data, rdy, f);
      cycles++;
      if (f) begin
        sent++;
        next_data++;
      end
    end
    n_checks++;
    if (sent != nwords)
      $display("FAIL %s word_count: got %0d words, want %0d", cur_test, sent, nwords);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    bit f;
    cur_test = "reset";
    @(negedge clk);
    a_rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 4'h0;
    @(posedge clk);
    step(0, 1'b1, 1'b0, 8'h00, 4'h0, f);
    step(0, 1'b1, 1'b0, 8'h5A, 4'hF, f);
    step(0, 1'b0, 1'b0, 8'hA5, 4'hF, f);
  endtask

  task automatic test_round_robin();
    int cyc;
    cur_test = "round_robin";
    clear_obs();
    next_data = 8'h00;
    stream(0, 16, 4'hF, 100, cyc);
    n_checks++;
    if (cyc !== 20) $display("FAIL %s cycles: got %0d, want 20", cur_test, cyc);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (k >= obs_ch.size())
        $display("FAIL %s word%0d: missing, want ch%0d", cur_test, k, k / 4);
      else if (obs_ch[k] !== k / 4 || obs_last[k] !== (k % 4 == 3) || obs_data[k] !== 8'(k))
        $display("FAIL %s word%0d: got ch%0d last=%b data=%h, want ch%0d last=%b data=%h",
                 cur_test, k, obs_ch[k], obs_last[k], obs_data[k], k / 4, (k % 4 == 3), 8'(k));
      else n_pass++;
    end
  endtask

  task automatic test_skip_unready();
    int cyc;
    cur_test = "skip_unready";
    clear_obs();
    stream(0, 4, 4'b0100, 20, cyc);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= obs_ch.size() || obs_ch[k] !== 2)
        $display("FAIL %s word%0d channel: got %0d, want 2", cur_test, k, (k < obs_ch.size()) ? obs_ch[k] : -1);
      else n_pass++;
    end
    clear_obs();
    stream(0, 1, 4'b0101, 20, cyc);
    n_checks++;
    if (obs_ch.size() < 1 || obs_ch[0] !== 0)
      $display("FAIL %s wrap_grant: got %0d, want 0", cur_test, (obs_ch.size() > 0) ? obs_ch[0] : -1);
    else n_pass++;
    stream(0, 3, 4'b0101, 20, cyc);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit f;
    cur_test = "backpressure";
    clear_obs();
    stream(0, 2, 4'hF, 20, cyc);
    for (int k = 0; k < 3; k++) begin
      step(0, 1'b0, 1'b1, next_data, 4'b1101, f);
      n_checks++;
      if (f !== 1'b0) $display("FAIL %s stall%0d: got transfer=%b, want 0", cur_test, k, f);
      else n_pass++;
    end
    stream(0, 2, 4'hF, 20, cyc);
    n_checks++;
    if (cyc !== 2) $display("FAIL %s resume_cycles: got %0d, want 2", cur_test, cyc);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= obs_ch.size() || obs_ch[k] !== 1 || obs_last[k] !== (k == 3))
        $display("FAIL %s word%0d: got ch%0d, want ch1 last=%b", cur_test, k,
                 (k < obs_ch.size()) ? obs_ch[k] : -1, (k == 3));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    bit f;
    cur_test = "reset_mid_burst";
    clear_obs();
    stream(0, 2, 4'b1000, 20, cyc);
    n_checks++;
    if (obs_ch.size() != 2 || obs_ch[0] !== 3 || obs_ch[1] !== 3)
      $display("FAIL %s pre_reset_channel: got %0d, want 3", cur_test, (obs_ch.size() > 0) ? obs_ch[0] : -1);
    else n_pass++;
    step(0, 1'b1, 1'b1, next_data, 4'hF, f);
    clear_obs();
    stream(0, 4, 4'hF, 20, cyc);
    n_checks++;
    if (cyc !== 5) $display("FAIL %s post_reset_cycles: got %0d, want 5", cur_test, cyc);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= obs_ch.size() || obs_ch[k] !== 0)
        $display("FAIL %s post_word%0d channel: got %0d, want 0", cur_test, k, (k < obs_ch.size()) ? obs_ch[k] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_random(input int d, input int ncycles);
    bit f;
    cur_test = (d == 0) ? "random_a" : "random_b";
    for (int i = 0; i < ncycles; i++)
      step(d, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), f);
  endtask

  task automatic test_burst1();
    int cyc;
    bit f;
    cur_test = "burst1";
    @(negedge clk);
    b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 2'b00;
    @(posedge clk);
    step(1, 1'b1, 1'b0, 8'h00, 4'h0, f);
    clear_obs();
    stream(1, 6, 4'b0011, 40, cyc);
    n_checks++;
    if (cyc !== 12) $display("FAIL %s cycles: got %0d, want 12", cur_test, cyc);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= obs_ch.size() || obs_ch[k] !== k % 2 || obs_last[k] !== 1'b1)
        $display("FAIL %s word%0d: got ch%0d, want ch%0d last=1", cur_test, k,
                 (k < obs_ch.size()) ? obs_ch[k] : -1, k % 2);
      else n_pass++;
    end
  endtask

  initial begin
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 4'h0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_done[i] = 0; m_ptr[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_skip_unready();
    test_backpressure();
    test_reset_mid_burst();
    test_random(0, 600);
    test_burst1();
    test_random(1, 300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_rr_dispatch.md
Name: demux_rr_dispatch

Overview:
- Sequences an N-way demux datapath: accepts a single valid/ready input word stream and dispatches it to one of seln = 2**swidth output channels in fixed-length bursts.
- Channel choice is round-robin among channels currently asserting ready. The choice is locked for a whole burst.
- Sits in front of per-channel consumers (FIFOs, engines) that share one upstream source.

Parameters:
- dwidth, 8, data bitwidth per word.
- swidth, 2, select bitwidth; channel count seln = 2**swidth (localparam).
- burst, 4, words per burst before re-arbitration; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  dwidth  upstream word.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- out_data  output  seln*dwidth  channel i occupies bits [i*dwidth +: dwidth]; non-selected slices are 0.
- out_valid  output  seln  per-channel valid, at most one bit set (one-hot or zero).
- out_ready  input  seln  per-channel ready.
- out_last  output  1  marks the final word of the current burst.
- cur_sel  output  swidth  channel owning the current burst.
- busy  output  1  high while in XFER.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ptr=0, cnt=0, cur_sel=0.
  - Outputs in_ready, out_valid, out_data, out_last and busy are all 0 while in IDLE.
  - Reset mid-burst truncates the burst: no further words go to that channel, and arbitration restarts from channel 0.
- Registers:
  - state in {IDLE, XFER}.
  - ptr[swidth-1:0]: round-robin start point.
  - cnt: width clog2(burst), minimum 1.
  - sel: drives cur_sel.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - If in_valid=1, scan channels in order ptr, ptr+1, ... mod seln and take the first i with out_ready[i]=1.
  - On a hit: register sel<=i, cnt<=0, state<=XFER.
  - If no channel is ready, or in_valid=0, stay in IDLE.
  - Arbitration costs exactly one bubble cycle per burst; no word moves in IDLE.
- XFER:
  - busy=1.
  - out_valid[sel]=in_valid; all other out_valid bits are 0.
  - out_data slice sel = in_data; all other slices are 0.
  - in_ready=out_ready[sel]; readiness of other channels is ignored.
  - out_last=(cnt==burst-1) && in_valid.
  - Transfer condition: in_valid && out_ready[sel]. No data is registered; input to output is zero latency (combinational).
  - On a transfer with cnt<burst-1: cnt<=cnt+1.
  - On a transfer with cnt==burst-1: ptr<=sel+1 (wraps at seln), cnt<=0, state<=IDLE.
  - No transfer: hold all state. Upstream stalls and downstream backpressure may last any number of cycles.
- Boundaries:
  - burst=1: every word is its own burst, and out_last is high with every valid word.
  - ptr wraps from seln-1 to 0.
  - Round-robin fairness: a channel that stays ready is granted within seln bursts.
  - in_valid and out_ready may drop mid-burst; the burst resumes on the same channel.
  - seln=2 (swidth=1) must work.
  - Simultaneous rst and transfer: reset wins.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> in_ready=0, out_valid=0, out_data=0, busy=0, cur_sel=0.
- Round-robin, defaults: out_ready=4'b1111, in_valid=1, data 0x00..0x0F streamed -> bursts to ch0, 1, 2, 3 in order, 4 words each; one bubble cycle between bursts; out_last high on words 0x03, 0x07, 0x0B, 0x0F.
- Skip unready: out_ready=4'b0100, ptr=0 -> burst goes to ch2; then with out_ready=4'b0101 the next grant is ch0 (ptr=3 wraps to 0).
- Backpressure mid-burst: ch1 owns the burst, drop out_ready[1] for 3 cycles after word 2 -> in_ready=0 and cnt held; raising other out_ready bits has no effect; words 3 and 4 then go to ch1.
- Reset mid-burst: rst=1 after 2 words to ch3 -> next burst starts at ch0 with cnt=0; ch3 receives no further words.
- burst=1, swidth=1: alternating grants ch0/ch1 with out_last=1 on every transfer; 2 cycles per word.
